control_acceso_memoria: RTL and testbench

Multi-cycle load/store initiator that sits between the datapath and the 32-word data memory. It accepts one byte, halfword or word request at a time over a valid/ready handshake. It drives the memory's `WD`/`Adress`/`MTW`/`MTR` pins and performs read-modify-write for sub-word stores. It returns aligned, optionally sign-extended load data over a valid/ready response channel.

---
 rtl/control_acceso_memoria_pkg.sv | 18 +
 rtl/control_acceso_memoria_alineador_bytes.sv | 41 ++++
 rtl/control_acceso_memoria.sv | 143 ++++++++++++++
 tb/tb_control_acceso_memoria.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_acceso_memoria_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states and default memory depth.
package control_acceso_memoria_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_ILEGAL = 2'b11;

    typedef logic [1:0] estado_t;

    localparam estado_t ST_IDLE  = 2'd0;
    localparam estado_t ST_READ  = 2'd1;
    localparam estado_t ST_WRITE = 2'd2;
    localparam estado_t ST_RESP  = 2'd3;

    localparam int MEM_WORDS_DEF = 32;

endpackage

// File: rtl/control_acceso_memoria_alineador_bytes.sv
// Byte-lane logic: extracts/extends load data from a memory word and merges store data into it.
module alineador_bytes
    import control_acceso_memoria_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sgn,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sgn & byte_sel[7]}}, byte_sel};
                store_word = word;
                store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{sgn & half_sel[15]}}, half_sel};
                store_word = word;
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/control_acceso_memoria.sv
// Multi-cycle load/store initiator for the 32-word data memory, with read-modify-write for sub-word stores.
// ALIGN_TRAP_EN: defined -> misaligned requests return rsp_err; undefined -> low address bits are silently cleared.
module control_acceso_memoria
    import control_acceso_memoria_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_addr,
    output logic        mem_mtw,
    output logic        mem_mtr,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_estado
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the response
    // holds rsp_valid and its data stable until that edge, and a request is only taken in IDLE.
    estado_t     estado;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_signed;
    logic        r_we;
    logic [31:0] r_wdata;

    logic [31:0] addr_al;
    logic [29:0] req_idx;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_ready  = (estado == ST_IDLE);
    assign dbg_estado = estado;

    always_comb begin
        addr_al = req_addr;
`ifndef ALIGN_TRAP_EN
        if (req_size == SZ_HALF)      addr_al[0]   = 1'b0;
        else if (req_size == SZ_WORD) addr_al[1:0] = 2'b00;
`endif
        req_idx = addr_al[31:2];
        req_err = (req_size == SZ_ILEGAL) || (req_idx >= 30'(MEM_WORDS));
`ifdef ALIGN_TRAP_EN
        if ((req_size == SZ_HALF && req_addr[0]) ||
            (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    alineador_bytes u_alineador (
        .size       (r_size),
        .lane       (r_lane),
        .sgn        (r_signed),
        .word       (mem_rd),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= ST_IDLE;
            r_size    <= SZ_BYTE;
            r_lane    <= 2'b00;
            r_signed  <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_wd    <= 32'h0;
            mem_addr  <= 32'h0;
            mem_mtw   <= 1'b0;
            mem_mtr   <= 1'b0;
        end else begin
            case (estado)
                ST_IDLE: if (req_valid) begin
                    r_size   <= req_size;
                    r_lane   <= addr_al[1:0];
                    r_signed <= req_signed;
                    r_we     <= req_we;
                    r_wdata  <= req_wdata;
                    if (req_err) begin
                        estado    <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        mem_addr <= {2'b00, req_idx};
                        // Full-word stores skip the read; everything else needs the current word first.
                        if (req_we && req_size == SZ_WORD) begin
                            estado  <= ST_WRITE;
                            mem_mtw <= 1'b1;
                            mem_wd  <= req_wdata;
                        end else begin
                            estado  <= ST_READ;
                            mem_mtr <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_mtr <= 1'b0;
                    if (r_we) begin
                        estado  <= ST_WRITE;
                        mem_mtw <= 1'b1;
                        mem_wd  <= store_word;
                    end else begin
                        estado    <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                    end
                end
                ST_WRITE: begin
                    mem_mtw   <= 1'b0;
                    estado    <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                ST_RESP: if (rsp_ready) begin
                    estado    <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_acceso_memoria.sv
// Directed bench for control_acceso_memoria with a behavioural 32-word memory beside the DUT.
module tb_control_acceso_memoria;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_wd;
    logic [31:0] mem_addr;
    logic        mem_mtw;
    logic        mem_mtr;
    logic [31:0] mem_rd;
    logic [1:0]  dbg_estado;

    logic [31:0] mem [0:31];

    int checks;
    int errors;

    int          lat;
    logic        saw_mtr;
    logic        saw_mtw;
    logic [31:0] wd_seen;
    logic        mtr_first;
    logic [31:0] addr_first;

    control_acceso_memoria dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_wd     (mem_wd),
        .mem_addr   (mem_addr),
        .mem_mtw    (mem_mtw),
        .mem_mtr    (mem_mtr),
        .mem_rd     (mem_rd),
        .dbg_estado (dbg_estado)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_rd = 32'h0;
        if (mem_mtr && mem_addr < 32) mem_rd = mem[mem_addr[4:0]];
    end

    always @(posedge clk) begin
        if (mem_mtw && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wd;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one request, waits for acceptance and then for rsp_valid; leaves rsp_ready low.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = ~sg;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat        = 1;
        saw_mtr    = 1'b0;
        saw_mtw    = 1'b0;
        wd_seen    = 32'h0;
        mtr_first  = mem_mtr;
        addr_first = mem_addr;
        while (!rsp_valid && lat < 10) begin
            if (mem_mtr) saw_mtr = 1'b1;
            if (mem_mtw) begin
                saw_mtw = 1'b1;
                wd_seen = mem_wd;
            end
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_rsp", {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'hCAFE_BABE;
        mem[2] = 32'h1122_3344;
        mem[3] = 32'h8000_00F1;

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", {28'b0, rsp_valid, rsp_err, mem_mtw, mem_mtr}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_state", 32'(dbg_estado), 32'd0);

        // load word
        issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
        chk("lw_mtr_n1", 32'(mtr_first), 32'd1);
        chk("lw_addr_n1", addr_first, 32'd3);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", rsp_rdata, 32'h8000_00F1);
        chk("lw_err", 32'(rsp_err), 32'd0);
        finish_rsp();

        // signed / unsigned byte loads
        issue(1'b0, 2'b00, 1'b1, 32'h0000_000C, 32'h0);
        chk("lb_s_data", rsp_rdata, 32'hFFFF_FFF1);
        chk("lb_s_lat", 32'(lat), 32'd2);
        finish_rsp();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0);
        chk("lb_u_data", rsp_rdata, 32'h0000_00F1);
        finish_rsp();

        // halfword store (read-modify-write)
        issue(1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_ABCD);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_read", 32'(saw_mtr), 32'd1);
        chk("sh_wd", wd_seen, 32'hABCD_3344);
        chk("sh_rdata", rsp_rdata, 32'h0);
        finish_rsp();
        chk("sh_mem", mem[2], 32'hABCD_3344);

        // signed halfword load of the upper lane
        issue(1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0);
        chk("lh_s_data", rsp_rdata, 32'hFFFF_ABCD);
        finish_rsp();

        // byte store to lane 1 of word 3
        issue(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_0055);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_wd", wd_seen, 32'h8000_55F1);
        finish_rsp();

        // misaligned word
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
`ifdef ALIGN_TRAP_EN
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(rsp_err), 32'd1);
        chk("mis_strobe", {30'b0, saw_mtr, saw_mtw}, 32'd0);
`else
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_err", 32'(rsp_err), 32'd0);
        chk("mis_data", rsp_rdata, 32'hCAFE_BABE);
`endif
        finish_rsp();

        // out of range
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", 32'(rsp_err), 32'd1);
        chk("oor_strobe", {30'b0, saw_mtr, saw_mtw}, 32'd0);
        chk("oor_rdata", rsp_rdata, 32'h0);
        finish_rsp();

        // illegal size
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h1);
        chk("ill_err", 32'(rsp_err), 32'd1);
        chk("ill_strobe", {30'b0, saw_mtr, saw_mtw}, 32'd0);
        finish_rsp();

        // word store
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h1234_5678);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_noread", 32'(saw_mtr), 32'd0);
        chk("sw_wd", wd_seen, 32'h1234_5678);
        finish_rsp();
        chk("sw_mem", mem[1], 32'h1234_5678);

        // backpressure: response must hold still
        issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_rdata, 32'h8000_55F1);
        end
        finish_rsp();

        // reset while in READ
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_000C;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rr_in_read", {30'b0, mem_mtr, req_ready}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_state", 32'(dbg_estado), 32'd0);
        chk("rr_ready", 32'(req_ready), 32'd1);
        chk("rr_outs", {28'b0, rsp_valid, rsp_err, mem_mtw, mem_mtr}, 32'd0);
        chk("rr_rdata", rsp_rdata, 32'h0);
        chk("rr_addr", mem_addr, 32'h0);
        chk("rr_wd", mem_wd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
